// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: clog2 for sizing pointers/level, bit positions of the
// sticky error flags as they appear in the MMIO status register.
package fifo_pkg;

  // Error-flag bit positions in the MMIO status word.
  localparam int ERR_OVERFLOW_BIT  = 0;
  localparam int ERR_UNDERFLOW_BIT = 1;
  localparam int ERR_BITS          = 2;

  // Ceiling log2, usable in constant (parameter) expressions.
  // clog2(1) = 0, clog2(6) = 3, clog2(8) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_ctrl: DEPTH x WIDTH, not reset.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none, the controller only writes free slots.
// Ports: clk; wr_en/wr_addr/wr_data synchronous write; rd_addr -> rd_data async read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO of any depth with threshold flags, occupancy and sticky errors.
// Latency: push visible in level/flags after 1 edge; read data 1 cycle after pop (FWFT=0) or show-ahead (FWFT=1).
// Backpressure: push at full is dropped (overflow) unless a pop lands in the same cycle; pop at empty is dropped (underflow).
// Ports: clk/rst (sync, active-high); wr_en/wr_data push; rd_en pop request;
//   rd_data/rd_valid read side; full/empty/almost_full/almost_empty/level status;
//   overflow/underflow sticky errors, cleared by clear_err.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 8,
  parameter int AF_MARGIN = 3,
  parameter int AE_LEVEL  = 1,
  parameter int FWFT      = 0,
  parameter int READ_EDGE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   level,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_err
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level_q;
  logic                rd_en_q;
  logic [ERR_BITS-1:0] err_q;
  logic [ERR_BITS-1:0] err_set;
  logic                pop_req;
  logic                pop_ok;
  logic                push_ok;
  logic [WIDTH-1:0]    mem_rd_data;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Status flags decode straight from the level register.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LW'(DEPTH));
  assign almost_full  = (int'(level_q) >= (DEPTH - AF_MARGIN));
  assign almost_empty = (int'(level_q) <= AE_LEVEL);
  assign level        = level_q;

  assign pop_req = (READ_EDGE != 0) ? (rd_en & ~rd_en_q) : rd_en;
  assign pop_ok  = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign push_ok = wr_en & (~full | pop_ok);

  always_comb begin
    err_set                    = '0;
    err_set[ERR_OVERFLOW_BIT]  = wr_en & ~push_ok;
    err_set[ERR_UNDERFLOW_BIT] = pop_req & ~pop_ok;
  end

  assign overflow  = err_q[ERR_OVERFLOW_BIT];
  assign underflow = err_q[ERR_UNDERFLOW_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rd_en_q <= 1'b0;
      err_q   <= '0;
    end else begin
      rd_en_q <= rd_en;
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      // New errors take priority over a same-cycle clear.
      err_q <= (err_q & ~{ERR_BITS{clear_err}}) | err_set;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head entry is always presented; a pop just advances rd_ptr.
    assign rd_data  = mem_rd_data;
    assign rd_valid = ~empty;
  end else begin : g_reg_read
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_ok;
        if (pop_ok) begin
          rd_data_q <= mem_rd_data;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised synchronous FIFO, successor to the current single-mode byte FIFO used between peripherals (UART/MMIO) and the core. Adds arbitrary (non-power-of-two) depth, exact full with programmable almost-full/almost-empty thresholds, selectable show-ahead (FWFT) or registered read, selectable level- or edge-triggered read, an occupancy output, and sticky overflow/underflow error flags.

## Interface
- DEPTH, 32: number of entries, ≥2, any integer.
- WIDTH, 8: data width in bits.
- AF_MARGIN, 3: almost_full asserts when level ≥ DEPTH−AF_MARGIN.
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL.
- FWFT, 0: 1 = show-ahead read; 0 = registered read, 1-cycle latency.
- READ_EDGE, 1: 1 = pop only on rising edge of rd_en; 0 = pop every cycle rd_en is high.

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  push request.
- wr_data  in  WIDTH  push data.
- rd_en  in  1  pop request (qualified by READ_EDGE).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- level  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: push rejected.
- underflow  out  1  sticky: pop rejected.
- clear_err  in  1  clears overflow/underflow.

## Operation
- pop_req = READ_EDGE ? (rd_en & ~rd_en_q) : rd_en; rd_en_q is a register, reset to 0.
- pop_ok = pop_req & ~empty. push_ok = wr_en & (~full | pop_ok).
- Push at full with simultaneous pop_ok: accepted, level unchanged. Push at empty with pop_req: push accepted, pop rejected, underflow set.
- level += push_ok − pop_ok; pointers wrap DEPTH−1 → 0 (explicit compare, no power-of-two masking).
- overflow set on wr_en & ~push_ok; underflow set on pop_req & ~pop_ok; clear_err clears both; set wins over clear in same cycle.
- FWFT=0: on pop_ok, rd_data ← mem[rd_ptr], rd_valid pulses 1 cycle; otherwise rd_valid = 0, rd_data holds.
- FWFT=1: rd_data = mem[rd_ptr] combinationally, rd_valid = ~empty; pop_ok advances to next word. rd_data don't-care when empty.
- All status flags are combinational decodes of the level register.
- Memory contents not reset.

## Timing
- Reset (any cycle, including mid-transfer): wr_ptr, rd_ptr, level, rd_en_q, rd_valid, overflow, underflow = 0; rd_data = 0 when FWFT=0; empty=1, almost_empty=1, others 0. Requests in the reset cycle ignored.
- Push at edge N: level/flags update after edge N; FWFT=1 data visible on rd_data after edge N if FIFO was empty.
- Pop (FWFT=0) at edge N: rd_data/rd_valid valid in cycle N+1.
- READ_EDGE=1: rd_en held high for k cycles yields exactly one pop; rd_en high on first cycle after reset counts as an edge.
- Throughput: one push and one pop per cycle (READ_EDGE=0).

## Structure
- Shared package fifo_pkg: clog2 function, error-flag bit indices for an MMIO status register.
- One sub-module: fifo_mem (WIDTH×DEPTH, one synchronous write port, one asynchronous read port); control, pointers, flags in sync_fifo_ctrl.

## Test plan
- DEPTH=8, AF_MARGIN=2: push 0x10..0x17 → almost_full at level 6, full=1 at level 8; 9th push 0x18 → overflow=1, level stays 8, 0x18 never read.
- FWFT=0, READ_EDGE=0: rd_en high 9 cycles after above fill → rd_data 0x10..0x17 with rd_valid each following cycle; 9th pop → rd_valid=0, underflow=1; clear_err → both flags 0.
- DEPTH=6: push 4, pop 4, push 6 (0x20..0x25) → full=1, pops return 0x20..0x25 in order across pointer wrap 5→0.
- Full + wr_en + pop same cycle → both accepted, level 8, overflow 0; empty + wr_en 0x55 + pop → level 1, underflow 1, next pop returns 0x55.
- READ_EDGE=1, 3 entries: rd_en held high 5 cycles → exactly one pop, level 2; drop/raise rd_en → second pop.
- FWFT=1: push 0xA5 into empty → rd_data=0xA5, rd_valid=1 next cycle; pop → empty=1, rd_valid=0; rst asserted with 4 entries → level 0, empty=1 next cycle.
